// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32I memory stage: funct3 load/store encodings,
// the request FSM state type and the byte-lane enable helper.
// Ports: none (package).
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  // Byte-enable mask for an access of width f3 at byte offset off.
  // Halfwords only look at off[1]; words (and undefined widths) use all lanes.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: lane_be = 4'b0001 << off;
      F3_H, F3_HU: lane_be = 4'b0011 << {off[1], 1'b0};
      default:     lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Purpose: store lane replication + byte enables, load lane extraction + sign/zero extension.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: st_f3/st_off/st_data -> st_be/st_lanes (store side);
//        ld_f3/ld_off/ld_word -> ld_data (load side).
module mem_lsu_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  st_f3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = lane_be(st_f3, st_off);
    st_lanes = st_data;
    case (st_f3)
      F3_B, F3_BU: st_lanes = {4{st_data[7:0]}};
      F3_H, F3_HU: st_lanes = {2{st_data[15:0]}};
      default:     st_lanes = st_data;
    endcase
  end

  always_comb begin
    ld_byte = 8'(ld_word >> {ld_off, 3'b000});
    ld_half = 16'(ld_word >> {ld_off[1], 4'b0000});
    ld_data = ld_word;
    case (ld_f3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// Purpose: RV32I M stage + M/W register, req/ack data-memory handshake with timeout abort.
// Latency: non-memory ops 1 cycle; memory ops issue cycle + ack cycle (>=2), result in W on the following edge.
// Backpressure: StallM_o holds upstream from issue until ack or timeout; no stall for non-memory ops.
// Ports: clk/rst; M-stage op inputs (ValidM_i..RdM_i); StallM_o; Dmem* request/response;
//        W-register outputs (ValidW_o..MisalignW_o).
// Optional feature macro: MEM_STAGE_MISALIGN_EN (trap misaligned half/word instead of aligning down).
module mem_stage_hs
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidM_i,
  input  logic              MemWriteM_i,
  input  logic              MemReadM_i,
  input  logic [2:0]        Funct3M_i,
  input  logic [31:0]       ALUResultM_i,
  input  logic [31:0]       WriteDataM_i,
  input  logic              RegWriteM_i,
  input  logic [4:0]        RdM_i,
  output logic              StallM_o,
  output logic              DmemReq_o,
  output logic              DmemWe_o,
  output logic [ADDR_W-1:0] DmemAddr_o,
  output logic [31:0]       DmemWdata_o,
  output logic [3:0]        DmemBe_o,
  input  logic              DmemAck_i,
  input  logic [31:0]       DmemRdata_i,
  output logic              ValidW_o,
  output logic              RegWriteW_o,
  output logic [4:0]        RdW_o,
  output logic [31:0]       ALUResultW_o,
  output logic [31:0]       ReadDataW_o,
  output logic              BusErrW_o,
  output logic              MisalignW_o
);

  // Counter only needs to reach TIMEOUT-1; expiry is the cycle it sits there with no ack.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  mem_state_e        state;
  logic [CNT_W-1:0]  tmo_cnt;

  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              req_we;
  logic [2:0]        req_f3;
  logic [1:0]        req_off;
  logic [4:0]        req_rd;
  logic              req_rw;
  logic [31:0]       req_alu;

  logic              mem_op, misal, issue, expire;
  logic [3:0]        st_be;
  logic [31:0]       st_lanes, ld_data;

  mem_lsu_align u_align (
    .st_f3    (Funct3M_i),
    .st_off   (ALUResultM_i[1:0]),
    .st_data  (WriteDataM_i),
    .st_be    (st_be),
    .st_lanes (st_lanes),
    .ld_f3    (req_f3),
    .ld_off   (req_off),
    .ld_word  (DmemRdata_i),
    .ld_data  (ld_data)
  );

  always_comb begin
    mem_op = ValidM_i & (MemReadM_i | MemWriteM_i);
    misal  = 1'b0;
`ifdef MEM_STAGE_MISALIGN_EN
    case (Funct3M_i)
      F3_B, F3_BU: misal = 1'b0;
      F3_H, F3_HU: misal = mem_op & ALUResultM_i[0];
      default:     misal = mem_op & (|ALUResultM_i[1:0]);
    endcase
`endif
    issue    = (state == IDLE) & mem_op & ~misal;
    expire   = (TIMEOUT != 0) & (state == BUSY) & ~DmemAck_i & (tmo_cnt == TMO_LAST);
    StallM_o = issue | ((state == BUSY) & ~DmemAck_i & ~expire);
  end

  assign DmemReq_o   = (state == BUSY);
  assign DmemWe_o    = req_we;
  assign DmemAddr_o  = req_addr;
  assign DmemWdata_o = req_wdata;
  assign DmemBe_o    = req_be;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_be       <= '0;
      req_we       <= 1'b0;
      req_f3       <= '0;
      req_off      <= '0;
      req_rd       <= '0;
      req_rw       <= 1'b0;
      req_alu      <= '0;
      ValidW_o     <= 1'b0;
      RegWriteW_o  <= 1'b0;
      RdW_o        <= '0;
      ALUResultW_o <= '0;
      ReadDataW_o  <= '0;
      BusErrW_o    <= 1'b0;
      MisalignW_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          BusErrW_o <= 1'b0;
          if (issue) begin
            state       <= BUSY;
            tmo_cnt     <= '0;
            req_addr    <= {ALUResultM_i[ADDR_W-1:2], 2'b00};
            req_wdata   <= st_lanes;
            req_be      <= st_be;
            req_we      <= MemWriteM_i;
            req_f3      <= Funct3M_i;
            req_off     <= ALUResultM_i[1:0];
            req_rd      <= RdM_i;
            req_rw      <= RegWriteM_i;
            req_alu     <= ALUResultM_i;
            ValidW_o    <= 1'b0;
            RegWriteW_o <= 1'b0;
            MisalignW_o <= 1'b0;
          end else begin
            ValidW_o     <= ValidM_i;
            RegWriteW_o  <= ValidM_i & RegWriteM_i & ~misal;
            RdW_o        <= RdM_i;
            ALUResultW_o <= ALUResultM_i;
            ReadDataW_o  <= '0;
            MisalignW_o  <= misal;
          end
        end
        BUSY: begin
          MisalignW_o <= 1'b0;
          if (DmemAck_i || expire) begin
            // Ack wins over a coincident expiry, so expire already excludes ack.
            state        <= IDLE;
            tmo_cnt      <= '0;
            ValidW_o     <= 1'b1;
            RegWriteW_o  <= req_rw & DmemAck_i;
            RdW_o        <= req_rd;
            ALUResultW_o <= req_alu;
            ReadDataW_o  <= (DmemAck_i && !req_we) ? ld_data : 32'h0;
            BusErrW_o    <= expire;
          end else begin
            tmo_cnt     <= tmo_cnt + 1'b1;
            ValidW_o    <= 1'b0;
            RegWriteW_o <= 1'b0;
            BusErrW_o   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_hs.sv
module tb_mem_stage_hs;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM_i, MemWriteM_i, MemReadM_i, RegWriteM_i, DmemAck_i;
  logic [2:0]  Funct3M_i;
  logic [31:0] ALUResultM_i, WriteDataM_i, DmemRdata_i;
  logic [4:0]  RdM_i;
  logic        StallM_o, DmemReq_o, DmemWe_o, ValidW_o, RegWriteW_o, BusErrW_o, MisalignW_o;
  logic [31:0] DmemAddr_o, DmemWdata_o, ALUResultW_o, ReadDataW_o;
  logic [3:0]  DmemBe_o;
  logic [4:0]  RdW_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage_hs #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ValidM_i(ValidM_i), .MemWriteM_i(MemWriteM_i), .MemReadM_i(MemReadM_i),
    .Funct3M_i(Funct3M_i), .ALUResultM_i(ALUResultM_i), .WriteDataM_i(WriteDataM_i),
    .RegWriteM_i(RegWriteM_i), .RdM_i(RdM_i), .StallM_o(StallM_o), .DmemReq_o(DmemReq_o),
    .DmemWe_o(DmemWe_o), .DmemAddr_o(DmemAddr_o), .DmemWdata_o(DmemWdata_o), .DmemBe_o(DmemBe_o),
    .DmemAck_i(DmemAck_i), .DmemRdata_i(DmemRdata_i), .ValidW_o(ValidW_o), .RegWriteW_o(RegWriteW_o),
    .RdW_o(RdW_o), .ALUResultW_o(ALUResultW_o), .ReadDataW_o(ReadDataW_o), .BusErrW_o(BusErrW_o),
    .MisalignW_o(MisalignW_o)
  );

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int acc_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int base_of(input logic [2:0] f3, input logic [31:0] addr);
    int n = acc_bytes(f3);
    int off = int'(addr % 4);
    if (n == 4) return 0;
    return (off / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int n = acc_bytes(f3);
    logic [3:0] be = '0;
    for (int i = 0; i < n; i++) be[base_of(f3, addr) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n = acc_bytes(f3);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
    int n = acc_bytes(f3);
    int b = base_of(f3, addr);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(b + i) +: 8];
    if (n < 4 && f3[2] == 1'b0 && v[8*n - 1]) begin
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MEM_STAGE_MISALIGN_EN
    int n = acc_bytes(f3);
    return (n > 1) && ((addr % n) != 0);
`else
    return (f3 == 3'b111) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ValidM_i = 0; MemWriteM_i = 0; MemReadM_i = 0; RegWriteM_i = 0;
    Funct3M_i = 0; ALUResultM_i = 0; WriteDataM_i = 0; RdM_i = 0;
    DmemAck_i = 0; DmemRdata_i = 0;
  endtask

  // Drive one op; lat = BUSY cycle in which ack arrives (0 = never ack).
  task automatic run_op(input bit mem, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input bit rw, input int lat,
                        input logic [31:0] rdat);
    bit mis, done, err;
    int stalls;
    mis = mem && m_misal(f3, addr);
    done = 0; err = 0;
    @(negedge clk);
    ValidM_i = 1; MemWriteM_i = mem & we; MemReadM_i = mem & ~we; Funct3M_i = f3;
    ALUResultM_i = addr; WriteDataM_i = wd; RegWriteM_i = rw; RdM_i = rd;
    #1;
    check("issue_stall", StallM_o, mem && !mis);
    check("issue_noreq", DmemReq_o, 0);
    stalls = StallM_o;
    if (mem && !mis) begin
      for (int k = 1; k <= 3 * TMO && !done; k++) begin
        @(negedge clk);
        check("busy_req", DmemReq_o, 1);
        check("busy_addr", DmemAddr_o, addr & ~32'h3);
        check("busy_be", DmemBe_o, m_be(f3, addr));
        check("busy_we", DmemWe_o, we);
        if (we) check("busy_wdata", DmemWdata_o, m_wdata(f3, wd));
        if (k == lat) begin
          DmemAck_i = 1; DmemRdata_i = rdat; done = 1;
        end else if (k == TMO) begin
          err = 1; done = 1;
        end
        #1;
        check("busy_stall", StallM_o, !done);
        stalls += int'(StallM_o);
      end
      check("bounded_completion", done, 1);
    end
    check("stall_cycles", stalls, (mem && !mis) ? (err ? TMO : lat) : 0);
    @(negedge clk);
    DmemAck_i = 0; ValidM_i = 0; MemWriteM_i = 0; MemReadM_i = 0;
    check("w_valid", ValidW_o, 1);
    check("w_regwrite", RegWriteW_o, rw && !err && !mis);
    check("w_rd", RdW_o, rd);
    check("w_alu", ALUResultW_o, addr);
    check("w_rdata", ReadDataW_o, (mem && !we && !err && !mis) ? m_load(f3, addr, rdat) : 32'h0);
    check("w_buserr", BusErrW_o, err);
    check("w_misalign", MisalignW_o, mis);
    check("post_noreq", DmemReq_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit we;
    logic [2:0] f3;
    int lat;
    idle_inputs();
    rst = 1;
    @(negedge clk); @(negedge clk);
    check("rst_stall", StallM_o, 0);
    check("rst_req", DmemReq_o, 0);
    check("rst_validw", ValidW_o, 0);
    check("rst_buserr", BusErrW_o, 0);
    check("rst_misalign", MisalignW_o, 0);
    check("rst_rdata", ReadDataW_o, 0);
    rst = 0;

    // Ack while idle is ignored.
    @(negedge clk); DmemAck_i = 1; DmemRdata_i = 32'h1234_5678;
    @(negedge clk); DmemAck_i = 0;
    check("idle_ack_req", DmemReq_o, 0);
    check("idle_ack_validw", ValidW_o, 0);

    // Directed cases.
    run_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd7, 1, 3, 32'hDEADBEEF);           // LW, 3-cycle ack
    run_op(1, 1, 3'b000, 32'h203, 32'h0000_00A5, 5'd0, 0, 1, 32'h0);          // SB lane 3
    run_op(1, 0, 3'b000, 32'h102, 32'h0, 5'd3, 1, 1, 32'h0080_0000);          // LB sign-ext
    run_op(1, 0, 3'b100, 32'h102, 32'h0, 5'd4, 1, 2, 32'h0080_0000);          // LBU zero-ext
    run_op(1, 1, 3'b001, 32'h302, 32'h0000_BEEF, 5'd0, 0, 1, 32'h0);          // SH upper half
    run_op(1, 0, 3'b001, 32'h402, 32'h0, 5'd9, 1, 1, 32'h8001_0000);          // LH sign-ext
    run_op(0, 0, 3'b000, 32'h0000_0055, 32'h0, 5'd11, 1, 0, 32'h0);           // ADD pass-through
    run_op(1, 0, 3'b010, 32'h500, 32'h0, 5'd12, 1, 0, 32'h0);                 // timeout
    run_op(1, 0, 3'b010, 32'h600, 32'h0, 5'd13, 1, TMO, 32'hCAFE_F00D);       // ack on expiry cycle
    run_op(1, 0, 3'b010, 32'h102, 32'h0, 5'd14, 1, 1, 32'h1111_2222);         // misaligned LW
    run_op(0, 0, 3'b000, 32'h0000_0077, 32'h0, 5'd15, 0, 0, 32'h0);           // pass-through after

    // Reset during the second BUSY cycle drops the request.
    @(negedge clk);
    ValidM_i = 1; MemReadM_i = 1; Funct3M_i = 3'b010; ALUResultM_i = 32'h700; RdM_i = 5'd5; RegWriteM_i = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1; ValidM_i = 0; MemReadM_i = 0;
    @(negedge clk);
    rst = 0;
    check("rstbusy_req", DmemReq_o, 0);
    check("rstbusy_validw", ValidW_o, 0);
    DmemAck_i = 1; DmemRdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    DmemAck_i = 0;
    check("late_ack_validw", ValidW_o, 0);
    check("late_ack_req", DmemReq_o, 0);

    // Randomized ops against the model.
    for (int n = 0; n < 80; n++) begin
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO);
      run_op($urandom_range(0, 3) != 0, we, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), lat, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
